// File: rtl/maze_nav_pkg.sv
// Shared types for the maze navigator: FSM states, wall-follow strategy,
// 2-bit compass index and the index-to-heading decode.
package maze_nav_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MOVE,
      ST_DECIDE,
      ST_HDNG_STRT,
      ST_HDNG_WAIT,
      ST_DONE,
      ST_ERR
   } state_t;

   typedef enum logic [1:0] {
      STRAT_LEFT   = 2'b00,
      STRAT_RIGHT  = 2'b01,
      STRAT_ALT    = 2'b10,
      STRAT_LEFT_X = 2'b11
   } strat_t;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_N = 2'd0;
   localparam dir_t DIR_W = 2'd1;
   localparam dir_t DIR_S = 2'd2;
   localparam dir_t DIR_E = 2'd3;

   // Turns are index deltas, applied mod 4.
   localparam dir_t TURN_LEFT  = 2'd1;
   localparam dir_t TURN_UTURN = 2'd2;
   localparam dir_t TURN_RIGHT = 2'd3;

   function automatic logic [31:0] hdng_decode(input dir_t dir, input int unsigned hdng_w);
      logic [31:0] quarter;
      logic [31:0] res;
      quarter = 32'd1 << (hdng_w - 32'd2);
      case (dir)
         DIR_N:   res = 32'd0;
         DIR_W:   res = quarter - 32'd1;
         DIR_S:   res = (quarter << 1) - 32'd1;
         default: res = quarter * 32'd3;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/maze_nav_tmo.sv
// Watchdog for mv_cmplt: down-counter reloaded on clr, expires when it has
// counted TMO_CYC enabled cycles.
module maze_nav_tmo #(
   parameter int unsigned TMO_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
   localparam logic [TW-1:0] LOAD = TW'(TMO_CYC - 1);

   logic [TW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= LOAD;
      end else if (clr) begin
         cnt <= LOAD;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - TW'(1);
      end
   end

   assign expired = en && (cnt == '0);

endmodule

// File: rtl/maze_nav.sv
// Wall-following maze solver sequencer: issues heading and move requests to
// the motion block and counts forward moves until the goal is reported.
//
// state        | meaning
// IDLE         | held by cmd_md=1; leaving it starts the first move
// MOVE         | forward move in progress, waiting for mv_cmplt
// DECIDE       | one cycle: goal check, then pick turn or forward
// HDNG_STRT    | one-cycle strt_hdng pulse
// HDNG_WAIT    | heading change in progress, waiting for mv_cmplt
// DONE         | goal found, done held until cmd_md=1
// ERR          | mv_cmplt timeout, err held until cmd_md=1
module maze_nav
   import maze_nav_pkg::*;
#(
   parameter int unsigned HDNG_W  = 12,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned TMO_CYC = 1_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_md,
   input  logic [1:0]        strat,
   input  logic              lft_opn,
   input  logic              frwrd_opn,
   input  logic              rght_opn,
   input  logic              mv_cmplt,
   input  logic              sol_cmplt,
   output logic              strt_hdng,
   output logic              strt_mv,
   output logic [HDNG_W-1:0] dsrd_hdng,
   output logic [CNT_W-1:0]  mv_cnt,
   output logic              done,
   output logic              err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state, state_nxt;
   strat_t strat_q;
   logic   alt_left_q;
   dir_t   hdng_idx_q, hdng_idx_nxt;
   dir_t   turn;
   logic   go_fwd;
   logic   pref_left;
   logic   issue_mv;
   logic   hdng_upd;
   logic   tmo_clr, tmo_en, tmo_exp;

   // 11 falls through to left-wall.
   assign pref_left = (strat_q == STRAT_RIGHT) ? 1'b0 :
                      (strat_q == STRAT_ALT)   ? alt_left_q : 1'b1;

   always_comb begin
      state_nxt    = state;
      issue_mv     = 1'b0;
      hdng_upd     = 1'b0;
      hdng_idx_nxt = hdng_idx_q;
      turn         = TURN_UTURN;
      go_fwd       = 1'b0;

      if (pref_left) begin
         if (lft_opn)        turn   = TURN_LEFT;
         else if (frwrd_opn) go_fwd = 1'b1;
         else if (rght_opn)  turn   = TURN_RIGHT;
      end else begin
         if (rght_opn)       turn   = TURN_RIGHT;
         else if (frwrd_opn) go_fwd = 1'b1;
         else if (lft_opn)   turn   = TURN_LEFT;
      end

      case (state)
         ST_IDLE: begin
            if (!cmd_md) begin
               state_nxt = ST_MOVE;
               issue_mv  = 1'b1;
            end
         end
         ST_MOVE: begin
            if (mv_cmplt)     state_nxt = ST_DECIDE;
            else if (tmo_exp) state_nxt = ST_ERR;
         end
         ST_DECIDE: begin
            if (sol_cmplt) begin
               state_nxt = ST_DONE;
            end else if (go_fwd) begin
               state_nxt = ST_MOVE;
               issue_mv  = 1'b1;
            end else begin
               state_nxt    = ST_HDNG_STRT;
               hdng_upd     = 1'b1;
               hdng_idx_nxt = hdng_idx_q + turn;
            end
         end
         ST_HDNG_STRT: state_nxt = ST_HDNG_WAIT;
         ST_HDNG_WAIT: begin
            if (mv_cmplt) begin
               state_nxt = ST_MOVE;
               issue_mv  = 1'b1;
            end else if (tmo_exp) begin
               state_nxt = ST_ERR;
            end
         end
         ST_DONE, ST_ERR: begin
            if (cmd_md) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         strat_q    <= STRAT_LEFT;
         alt_left_q <= 1'b1;
         hdng_idx_q <= DIR_N;
         dsrd_hdng  <= '0;
         mv_cnt     <= '0;
         strt_mv    <= 1'b0;
      end else begin
         state   <= state_nxt;
         strt_mv <= issue_mv;

         if ((state == ST_IDLE) && !cmd_md) begin
            strat_q    <= strat_t'(strat);
            alt_left_q <= 1'b1;
         end else if (state == ST_DECIDE) begin
            alt_left_q <= ~alt_left_q;
         end

         if (hdng_upd) begin
            hdng_idx_q <= hdng_idx_nxt;
            dsrd_hdng  <= HDNG_W'(hdng_decode(hdng_idx_nxt, HDNG_W));
         end

         // A new solve restarts the count, so its first move reads 1.
         if (issue_mv) begin
            if (state == ST_IDLE)      mv_cnt <= CNT_W'(1);
            else if (mv_cnt != CNT_MAX) mv_cnt <= mv_cnt + CNT_W'(1);
         end
      end
   end

   assign strt_hdng = (state == ST_HDNG_STRT);
   assign done      = (state == ST_DONE);
   assign err       = (state == ST_ERR);

   assign tmo_clr = (state_nxt != state);
   assign tmo_en  = ((state == ST_MOVE) || (state == ST_HDNG_WAIT)) && !mv_cmplt;

   maze_nav_tmo #(
      .TMO_CYC(TMO_CYC)
   ) u_tmo (
      .clk    (clk),
      .rst    (rst),
      .clr    (tmo_clr),
      .en     (tmo_en),
      .expired(tmo_exp)
   );

endmodule

// File: tb/tb_maze_nav.sv
// Directed bench for maze_nav: per-cycle vector table plus hand sequences
// for timeout, counter saturation and asynchronous reset.
module tb_maze_nav;

   typedef struct {
      logic        rst;
      logic        cmd;
      logic [1:0]  strat;
      logic        l, f, r, mc, sc;
      logic        e_sh, e_sm;
      logic [11:0] e_hd;
      logic [7:0]  e_cnt;
      logic        e_done, e_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cmd_md = 1'b1;
   logic [1:0] strat = 2'b00;
   logic lft_opn = 1'b0, frwrd_opn = 1'b0, rght_opn = 1'b0;
   logic mv_cmplt = 1'b0, sol_cmplt = 1'b0;

   logic        strt_hdng, strt_mv, done, err;
   logic [11:0] dsrd_hdng;
   logic [7:0]  mv_cnt;
   logic        b_strt_hdng, b_strt_mv, b_done, b_err;
   logic [11:0] b_dsrd_hdng;
   logic [1:0]  b_mv_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t vecs[$];

   maze_nav #(.HDNG_W(12), .CNT_W(8), .TMO_CYC(16)) dut (
      .clk(clk), .rst(rst), .cmd_md(cmd_md), .strat(strat),
      .lft_opn(lft_opn), .frwrd_opn(frwrd_opn), .rght_opn(rght_opn),
      .mv_cmplt(mv_cmplt), .sol_cmplt(sol_cmplt),
      .strt_hdng(strt_hdng), .strt_mv(strt_mv), .dsrd_hdng(dsrd_hdng),
      .mv_cnt(mv_cnt), .done(done), .err(err)
   );

   maze_nav #(.HDNG_W(12), .CNT_W(2), .TMO_CYC(16)) dut_sat (
      .clk(clk), .rst(rst), .cmd_md(cmd_md), .strat(strat),
      .lft_opn(lft_opn), .frwrd_opn(frwrd_opn), .rght_opn(rght_opn),
      .mv_cmplt(mv_cmplt), .sol_cmplt(sol_cmplt),
      .strt_hdng(b_strt_hdng), .strt_mv(b_strt_mv), .dsrd_hdng(b_dsrd_hdng),
      .mv_cnt(b_mv_cnt), .done(b_done), .err(b_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r_, input logic c, input logic [1:0] s,
                               input logic l, input logic f, input logic g,
                               input logic mc, input logic sc,
                               input logic sh, input logic sm, input logic [11:0] hd,
                               input logic [7:0] cn, input logic dn, input logic er);
      vec_t v;
      v.rst = r_; v.cmd = c; v.strat = s;
      v.l = l; v.f = f; v.r = g; v.mc = mc; v.sc = sc;
      v.e_sh = sh; v.e_sm = sm; v.e_hd = hd; v.e_cnt = cn; v.e_done = dn; v.e_err = er;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Heading and move requests must never coincide.
   always @(negedge clk) begin
      if (!rst) begin
         chk("excl", {31'b0, strt_hdng & strt_mv}, 32'd0);
         chk("excl_sat", {31'b0, b_strt_hdng & b_strt_mv}, 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      //            rst cmd st  l f r mc sc  sh sm hd     cnt dn er
      // left-wall: left turn, U-turns from W and E, goal, return to idle
      vecs.push_back(mk(1, 1, 0, 0,0,0, 0,0,  0,0, 12'h000, 0, 0,0));
      vecs.push_back(mk(0, 0, 0, 1,0,0, 0,0,  0,1, 12'h000, 1, 0,0));
      vecs.push_back(mk(0, 0, 0, 1,0,0, 1,0,  0,0, 12'h000, 1, 0,0));
      vecs.push_back(mk(0, 0, 0, 1,0,0, 0,0,  1,0, 12'h3FF, 1, 0,0));
      vecs.push_back(mk(0, 0, 0, 1,0,0, 1,0,  0,0, 12'h3FF, 1, 0,0));
      vecs.push_back(mk(0, 0, 0, 1,0,0, 0,0,  0,0, 12'h3FF, 1, 0,0));
      vecs.push_back(mk(0, 0, 0, 1,0,0, 1,0,  0,1, 12'h3FF, 2, 0,0));
      vecs.push_back(mk(0, 0, 0, 0,0,0, 1,0,  0,0, 12'h3FF, 2, 0,0));
      vecs.push_back(mk(0, 0, 0, 0,0,0, 0,0,  1,0, 12'hC00, 2, 0,0));
      vecs.push_back(mk(0, 0, 0, 0,0,0, 0,0,  0,0, 12'hC00, 2, 0,0));
      vecs.push_back(mk(0, 0, 0, 0,0,0, 1,0,  0,1, 12'hC00, 3, 0,0));
      vecs.push_back(mk(0, 0, 0, 0,0,0, 1,0,  0,0, 12'hC00, 3, 0,0));
      vecs.push_back(mk(0, 0, 0, 0,0,0, 0,0,  1,0, 12'h3FF, 3, 0,0));
      vecs.push_back(mk(0, 0, 0, 0,0,0, 0,0,  0,0, 12'h3FF, 3, 0,0));
      vecs.push_back(mk(0, 0, 0, 0,0,0, 0,1,  0,0, 12'h3FF, 3, 0,0));
      vecs.push_back(mk(0, 0, 0, 0,0,0, 1,0,  0,1, 12'h3FF, 4, 0,0));
      vecs.push_back(mk(0, 0, 0, 0,0,0, 1,0,  0,0, 12'h3FF, 4, 0,0));
      vecs.push_back(mk(0, 0, 0, 1,0,0, 0,1,  0,0, 12'h3FF, 4, 1,0));
      vecs.push_back(mk(0, 0, 0, 1,0,0, 1,1,  0,0, 12'h3FF, 4, 1,0));
      vecs.push_back(mk(0, 1, 0, 1,0,0, 0,0,  0,0, 12'h3FF, 4, 0,0));
      vecs.push_back(mk(0, 1, 0, 1,0,0, 0,0,  0,0, 12'h3FF, 4, 0,0));
      // right-wall, forward only; cmd_md ignored mid-move; strat latched
      vecs.push_back(mk(1, 1, 1, 0,1,0, 0,0,  0,0, 12'h000, 0, 0,0));
      vecs.push_back(mk(0, 0, 1, 0,1,0, 0,0,  0,1, 12'h000, 1, 0,0));
      vecs.push_back(mk(0, 0, 1, 0,1,0, 1,0,  0,0, 12'h000, 1, 0,0));
      vecs.push_back(mk(0, 0, 1, 0,1,0, 0,0,  0,1, 12'h000, 2, 0,0));
      vecs.push_back(mk(0, 0, 1, 0,1,0, 1,0,  0,0, 12'h000, 2, 0,0));
      vecs.push_back(mk(0, 0, 1, 0,1,0, 0,0,  0,1, 12'h000, 3, 0,0));
      vecs.push_back(mk(0, 1, 1, 0,1,0, 0,0,  0,0, 12'h000, 3, 0,0));
      vecs.push_back(mk(0, 0, 1, 0,1,0, 1,0,  0,0, 12'h000, 3, 0,0));
      vecs.push_back(mk(0, 0, 0, 1,1,1, 0,0,  1,0, 12'hC00, 3, 0,0));
      // alternate: left, right, left
      vecs.push_back(mk(1, 1, 2, 1,0,1, 0,0,  0,0, 12'h000, 0, 0,0));
      vecs.push_back(mk(0, 0, 2, 1,0,1, 0,0,  0,1, 12'h000, 1, 0,0));
      vecs.push_back(mk(0, 0, 2, 1,0,1, 1,0,  0,0, 12'h000, 1, 0,0));
      vecs.push_back(mk(0, 0, 2, 1,0,1, 0,0,  1,0, 12'h3FF, 1, 0,0));
      vecs.push_back(mk(0, 0, 2, 1,0,1, 0,0,  0,0, 12'h3FF, 1, 0,0));
      vecs.push_back(mk(0, 0, 2, 1,0,1, 1,0,  0,1, 12'h3FF, 2, 0,0));
      vecs.push_back(mk(0, 0, 2, 1,0,1, 1,0,  0,0, 12'h3FF, 2, 0,0));
      vecs.push_back(mk(0, 0, 2, 1,0,1, 0,0,  1,0, 12'h000, 2, 0,0));
      vecs.push_back(mk(0, 0, 2, 1,0,1, 0,0,  0,0, 12'h000, 2, 0,0));
      vecs.push_back(mk(0, 0, 2, 1,0,1, 1,0,  0,1, 12'h000, 3, 0,0));
      vecs.push_back(mk(0, 0, 2, 1,0,1, 1,0,  0,0, 12'h000, 3, 0,0));
      vecs.push_back(mk(0, 0, 2, 1,0,1, 0,0,  1,0, 12'h3FF, 3, 0,0));
      // strategy 11 behaves as left-wall
      vecs.push_back(mk(1, 1, 3, 1,0,1, 0,0,  0,0, 12'h000, 0, 0,0));
      vecs.push_back(mk(0, 0, 3, 1,0,1, 0,0,  0,1, 12'h000, 1, 0,0));
      vecs.push_back(mk(0, 0, 3, 1,0,1, 1,0,  0,0, 12'h000, 1, 0,0));
      vecs.push_back(mk(0, 0, 3, 1,0,1, 0,0,  1,0, 12'h3FF, 1, 0,0));

      repeat (2) step();
      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; cmd_md = vecs[i].cmd; strat = vecs[i].strat;
         lft_opn = vecs[i].l; frwrd_opn = vecs[i].f; rght_opn = vecs[i].r;
         mv_cmplt = vecs[i].mc; sol_cmplt = vecs[i].sc;
         step();
         chk($sformatf("row%0d strt_hdng", i), {31'b0, strt_hdng}, {31'b0, vecs[i].e_sh});
         chk($sformatf("row%0d strt_mv", i),   {31'b0, strt_mv},   {31'b0, vecs[i].e_sm});
         chk($sformatf("row%0d dsrd_hdng", i), {20'b0, dsrd_hdng}, {20'b0, vecs[i].e_hd});
         chk($sformatf("row%0d mv_cnt", i),    {24'b0, mv_cnt},    {24'b0, vecs[i].e_cnt});
         chk($sformatf("row%0d done", i),      {31'b0, done},      {31'b0, vecs[i].e_done});
         chk($sformatf("row%0d err", i),       {31'b0, err},       {31'b0, vecs[i].e_err});
      end

      // timeout: 16 cycles in MOVE without mv_cmplt
      rst = 1; cmd_md = 1; strat = 0; lft_opn = 0; frwrd_opn = 0; rght_opn = 0;
      mv_cmplt = 0; sol_cmplt = 0;
      step();
      rst = 0; cmd_md = 0;
      step();
      chk("tmo_first_mv", {31'b0, strt_mv}, 32'd1);
      repeat (15) step();
      chk("tmo_edge_err", {31'b0, err}, 32'd0);
      step();
      chk("tmo_err", {31'b0, err}, 32'd1);
      chk("tmo_cnt_hold", {24'b0, mv_cnt}, 32'd1);
      mv_cmplt = 1;
      step();
      chk("tmo_err_sticky", {31'b0, err}, 32'd1);
      chk("tmo_no_mv", {31'b0, strt_mv}, 32'd0);
      mv_cmplt = 0; cmd_md = 1;
      step();
      chk("tmo_clear", {31'b0, err}, 32'd0);
      chk("tmo_idle_cnt", {24'b0, mv_cnt}, 32'd1);

      // five forward moves: narrow counter saturates at 3
      rst = 1; cmd_md = 1;
      step();
      rst = 0; cmd_md = 0; strat = 2'b01; frwrd_opn = 1;
      step();
      for (int k = 0; k < 4; k++) begin
         mv_cmplt = 1; step();
         mv_cmplt = 0; step();
         if (k == 1) chk("sat_cnt3", {30'b0, b_mv_cnt}, 32'd3);
      end
      chk("wide_cnt5", {24'b0, mv_cnt}, 32'd5);
      chk("sat_cnt", {30'b0, b_mv_cnt}, 32'd3);

      // asynchronous reset mid-operation
      rst = 1; cmd_md = 1;
      step();
      rst = 0; cmd_md = 0; strat = 0; lft_opn = 1; frwrd_opn = 0;
      step();
      mv_cmplt = 1; step();
      mv_cmplt = 0; step();
      chk("ar_pre_sh", {31'b0, strt_hdng}, 32'd1);
      chk("ar_pre_hd", {20'b0, dsrd_hdng}, 32'h3FF);
      #2 rst = 1;
      #1;
      chk("ar_sh", {31'b0, strt_hdng}, 32'd0);
      chk("ar_hd", {20'b0, dsrd_hdng}, 32'd0);
      chk("ar_cnt", {24'b0, mv_cnt}, 32'd0);
      cmd_md = 1;
      step();
      rst = 0;
      step();
      chk("ar_idle_mv", {31'b0, strt_mv}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/maze_nav.md
MAZE_NAV -- requirements
Module: maze_nav

Interface
REQ-001 Parameters SHALL be: HDNG_W, default 12, heading width (>=4); CNT_W, default 8, move-counter width; TMO_CYC, default 1_000_000, max cycles waiting for mv_cmplt.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_md  in  1  1 = command mode (hold idle); 0 = autonomous solve request
- strat  in  2  00 left-wall, 01 right-wall, 10 alternate (flip preference each decision), 11 treated as 00
- lft_opn, frwrd_opn, rght_opn  in  1 each  wall sensors, valid whenever sampled
- mv_cmplt  in  1  one-cycle pulse: current heading or move finished
- sol_cmplt  in  1  level: magnet/goal found
- strt_hdng  out  1  one-cycle pulse: begin heading change
- strt_mv  out  1  one-cycle pulse: begin forward move
- dsrd_hdng  out  HDNG_W  registered desired heading
- mv_cnt  out  CNT_W  forward moves issued, saturating
- done  out  1  level: solve finished
- err  out  1  level: mv_cmplt timeout

Function
REQ-003 Headings SHALL encode N=0, W=2^(HDNG_W-2)-1, S=2^(HDNG_W-1)-1, E=3*2^(HDNG_W-2); for HDNG_W=12 these are 000, 3FF, 7FF, C00.
REQ-004 Block SHALL track heading as 2-bit index (N=0,W=1,S=2,E=3); left = +1, right = -1, U-turn = +2, all mod 4; dsrd_hdng SHALL be the decoded index.
REQ-005 States SHALL be IDLE, MOVE, DECIDE, HDNG_STRT, HDNG_WAIT, DONE, ERR.
REQ-006 IDLE: when cmd_md=0, latch strat, pulse strt_mv, increment mv_cnt, go to MOVE next cycle.
REQ-007 MOVE: on mv_cmplt go to DECIDE.
REQ-008 DECIDE (one cycle): if sol_cmplt go to DONE; otherwise choose by preference order.
- left preference: left, forward, right, U-turn; right preference: right, forward, left, U-turn.
- Alternate mode starts with left preference and toggles after every DECIDE.
REQ-009 Forward choice SHALL leave dsrd_hdng unchanged, pulse strt_mv, increment mv_cnt and go to MOVE, skipping the heading phase.
REQ-010 Turn choices SHALL update dsrd_hdng at the DECIDE clock edge and go to HDNG_STRT.
REQ-011 HDNG_STRT SHALL pulse strt_hdng for exactly one cycle, then go to HDNG_WAIT.
REQ-012 HDNG_WAIT: on mv_cmplt pulse strt_mv, increment mv_cnt, go to MOVE.
REQ-013 mv_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-014 In MOVE and HDNG_WAIT a cycle counter SHALL count while mv_cmplt=0; at TMO_CYC go to ERR; it clears on every state change.
REQ-015 DONE and ERR SHALL assert done/err as levels, issue no pulses, and return to IDLE only when cmd_md=1; mv_cnt and dsrd_hdng hold.
REQ-016 Leaving IDLE SHALL clear mv_cnt to 0 before incrementing, so the first move reads 1.
REQ-017 cmd_md changes outside IDLE/DONE/ERR SHALL be ignored.
REQ-018 sol_cmplt SHALL be sampled only in DECIDE; mv_cmplt in any other state SHALL be ignored.
REQ-019 strt_hdng and strt_mv SHALL never assert in the same cycle.

Reset
REQ-020 On rst: state IDLE, dsrd_hdng 0 (N), heading index 0, mv_cnt 0, preference left, timeout counter 0, and all pulses, done and err 0; this applies immediately and mid-operation.

Structure
REQ-021 Package maze_nav_pkg SHALL hold the state enum, strategy enum, 2-bit direction type, and a heading-decode function parameterised by HDNG_W.
REQ-022 Sub-module maze_nav_tmo SHALL implement the clearable timeout counter (TMO_CYC, clr, en, expired).

Verification
REQ-023 Reset, then cmd_md=0, strat=00, sensors lft=1 -> strt_mv at cycle 1; after mv_cmplt, dsrd_hdng=3FF, strt_hdng pulses once, mv_cnt=1.
REQ-024 strat=01 with only frwrd_opn=1 for three moves -> dsrd_hdng stays 000, no strt_hdng, mv_cnt=3.
REQ-025 All sensors closed from E (C00) -> dsrd_hdng=3FF (U-turn); strt_hdng then strt_mv after mv_cmplt.
REQ-026 strat=10 with lft=rght=1, frwrd=0 -> successive headings 3FF, 000, 3FF.
REQ-027 TMO_CYC=16 with mv_cmplt withheld -> err=1 after 16 cycles; cmd_md=1 returns IDLE, err=0.
REQ-028 sol_cmplt=1 at DECIDE -> done=1, no further pulses; CNT_W=2 with 5 forward moves -> mv_cnt=3.
